// File: rtl/iec_sd_arbiter_pkg.sv
// Shared definitions for the SD-card host arbiter: FSM encoding and drive-count limit.
package iec_sd_arbiter_pkg;

    localparam int MAX_DRIVES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/iec_sd_arbiter_rr_pick.sv
// Round-robin pick: first requesting drive found scanning from (last+1) mod DRIVES.
module rr_pick
    import iec_sd_arbiter_pkg::*;
#(
    parameter int DRIVES = 2
) (
    input  logic [DRIVES-1:0] req_i,
    input  logic [1:0]        last_i,
    output logic              valid_o,
    output logic [1:0]        idx_o
);

    logic [2:0]        cand [DRIVES];
    logic [DRIVES-1:0] hit;
    logic [DRIVES:0]   seen;
    logic [1:0]        acc  [DRIVES+1];

    assign seen[0] = 1'b0;
    assign acc[0]  = 2'b00;

    // Candidate gi is the drive gi+1 positions after last; the earliest hit wins.
    generate
        for (genvar gi = 0; gi < DRIVES; gi++) begin : g_scan
            logic [2:0] sum;
            assign sum         = {1'b0, last_i} + 3'(gi + 1);
            assign cand[gi]    = (sum >= 3'(DRIVES)) ? sum - 3'(DRIVES) : sum;
            assign hit[gi]     = |(req_i & (DRIVES'(1) << cand[gi]));
            assign seen[gi+1]  = seen[gi] | hit[gi];
            assign acc[gi+1]   = acc[gi] | ((hit[gi] && !seen[gi]) ? cand[gi][1:0] : 2'b00);
        end
    endgenerate

    assign valid_o = seen[DRIVES];
    assign idx_o   = acc[DRIVES];

endmodule

// File: rtl/iec_sd_arbiter.sv
// Shares one SD-card host channel between up to four drive ports, granting
// one drive per block transfer in round-robin order.
module iec_sd_arbiter
    import iec_sd_arbiter_pkg::*;
#(
    parameter int DRIVES = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [32*DRIVES-1:0]  drv_sd_lba,
    input  logic [DRIVES-1:0]     drv_sd_rd,
    input  logic [DRIVES-1:0]     drv_sd_wr,
    output logic [DRIVES-1:0]     drv_sd_ack,
    input  logic [8*DRIVES-1:0]   drv_sd_buff_din,
    output logic [DRIVES-1:0]     drv_sd_buff_wr,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic                  sd_buff_wr,
    output logic [7:0]            sd_buff_din,
    output logic [1:0]            active,
    output logic                  busy
);

    arb_state_e state_q;
    logic [1:0]  idx_q;
    logic [1:0]  last_q;
    logic [31:0] sd_lba_q;
    logic        sd_rd_q;
    logic        sd_wr_q;

    logic [31:0]           lba_w [MAX_DRIVES];
    logic [7:0]            din_w [MAX_DRIVES];
    logic [MAX_DRIVES-1:0] rd_w;
    logic [MAX_DRIVES-1:0] wr_w;

    logic [DRIVES-1:0] req;
    logic              pick_valid;
    logic [1:0]        pick_idx;

    // Pad the per-drive buses out to the maximum so a 2-bit index is always in range.
    generate
        for (genvar gi = 0; gi < MAX_DRIVES; gi++) begin : g_unpack
            if (gi < DRIVES) begin : g_live
                assign lba_w[gi] = drv_sd_lba[32*gi +: 32];
                assign din_w[gi] = drv_sd_buff_din[8*gi +: 8];
                assign rd_w[gi]  = drv_sd_rd[gi];
                assign wr_w[gi]  = drv_sd_wr[gi];
            end else begin : g_pad
                assign lba_w[gi] = 32'h0;
                assign din_w[gi] = 8'h00;
                assign rd_w[gi]  = 1'b0;
                assign wr_w[gi]  = 1'b0;
            end
        end
    endgenerate

    assign req = drv_sd_rd | drv_sd_wr;

    rr_pick #(
        .DRIVES (DRIVES)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            last_q   <= 2'(DRIVES - 1);
            sd_lba_q <= 32'h0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        idx_q    <= pick_idx;
                        sd_lba_q <= lba_w[pick_idx];
                        sd_rd_q  <= rd_w[pick_idx];
                        sd_wr_q  <= wr_w[pick_idx] & ~rd_w[pick_idx];
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= ST_XFER;
                    end else if (!rd_w[idx_q] && !wr_w[idx_q]) begin
                        // Drive withdrew before the host answered: abandon, keep priority.
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (!sd_ack) begin
                        last_q  <= idx_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DRIVES; gi++) begin : g_route
            assign drv_sd_ack[gi]     = (state_q != ST_IDLE) && (idx_q == 2'(gi)) && sd_ack;
            assign drv_sd_buff_wr[gi] = (state_q == ST_XFER) && (idx_q == 2'(gi)) && sd_buff_wr;
        end
    endgenerate

    assign sd_buff_din = (state_q == ST_IDLE) ? 8'h00 : din_w[idx_q];
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign active      = idx_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Self-checking bench for iec_sd_arbiter: directed scenarios, then randomized
// request traffic checked against a round-robin reference model.
module tb_iec_sd_arbiter;

    localparam int D = 3;

    logic              clk_sys = 1'b0;
    logic              reset   = 1'b0;
    logic [32*D-1:0]   drv_sd_lba = '0;
    logic [D-1:0]      drv_sd_rd  = '0;
    logic [D-1:0]      drv_sd_wr  = '0;
    logic [D-1:0]      drv_sd_ack;
    logic [8*D-1:0]    drv_sd_buff_din = '0;
    logic [D-1:0]      drv_sd_buff_wr;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack     = 1'b0;
    logic              sd_buff_wr = 1'b0;
    logic [7:0]        sd_buff_din;
    logic [1:0]        active;
    logic              busy;

    iec_sd_arbiter #(.DRIVES(D)) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .drv_sd_lba      (drv_sd_lba),
        .drv_sd_rd       (drv_sd_rd),
        .drv_sd_wr       (drv_sd_wr),
        .drv_sd_ack      (drv_sd_ack),
        .drv_sd_buff_din (drv_sd_buff_din),
        .drv_sd_buff_wr  (drv_sd_buff_wr),
        .sd_lba          (sd_lba),
        .sd_rd           (sd_rd),
        .sd_wr           (sd_wr),
        .sd_ack          (sd_ack),
        .sd_buff_wr      (sd_buff_wr),
        .sd_buff_din     (sd_buff_din),
        .active          (active),
        .busy            (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: pending requests per drive (kind 0=rd, 1=wr, 2=both).
    int          last_m;
    logic [D-1:0] pend = '0;
    int          kind  [D];
    logic [31:0] lba_m [D];
    logic [7:0]  din_m [D];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic int model_pick(input logic [D-1:0] p, input int last);
        for (int k = 1; k <= D; k++) begin
            int c;
            c = (last + k) % D;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int d, input int k, input logic [31:0] lba, input logic [7:0] din);
        pend[d]  = 1'b1;
        kind[d]  = k;
        lba_m[d] = lba;
        din_m[d] = din;
    endtask

    task automatic apply();
        for (int i = 0; i < D; i++) begin
            drv_sd_rd[i] = pend[i] && (kind[i] != 1);
            drv_sd_wr[i] = pend[i] && (kind[i] != 0);
            drv_sd_lba[32*i +: 32]    = lba_m[i];
            drv_sd_buff_din[8*i +: 8] = din_m[i];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd", sd_rd, 0);
        chk("rst_wr", sd_wr, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_active", active, 0);
        chk("rst_ack", drv_sd_ack, 0);
        chk("rst_bwr", drv_sd_buff_wr, 0);
        step();
        step();
        reset  = 1'b0;
        last_m = D - 1;
    endtask

    // Called in IDLE with requests already applied; runs one full grant/transfer.
    task automatic run_txn(input int d, input bit keep, input int wait_n, input int ack_len);
        logic erd, ewr;
        erd = (kind[d] != 1);
        ewr = (kind[d] == 1);
        step();
        chk("grant_busy", busy, 1);
        chk("grant_active", active, d);
        chk("grant_rd", sd_rd, erd);
        chk("grant_wr", sd_wr, ewr);
        chk("grant_lba", sd_lba, lba_m[d]);
        chk("req_ack", drv_sd_ack, 0);
        chk("req_din", sd_buff_din, din_m[d]);
        for (int w = 0; w < wait_n; w++) begin
            step();
            chk("hold_rd", sd_rd, erd);
            chk("hold_lba", sd_lba, lba_m[d]);
        end
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        #1;
        chk("ack_route", drv_sd_ack, 64'(1) << d);
        chk("req_no_bwr", drv_sd_buff_wr, 0);
        sd_buff_wr = 1'b0;
        step();
        chk("xfer_rd", sd_rd, 0);
        chk("xfer_wr", sd_wr, 0);
        chk("xfer_busy", busy, 1);
        chk("xfer_lba", sd_lba, lba_m[d]);
        if (!keep) begin
            pend[d] = 1'b0;
            apply();
        end
        for (int i = 0; i < ack_len; i++) begin
            sd_buff_wr = i[0];
            #1;
            chk("xfer_bwr", drv_sd_buff_wr, i[0] ? (64'(1) << d) : 64'(0));
            chk("xfer_ack", drv_sd_ack, 64'(1) << d);
            chk("xfer_din", sd_buff_din, din_m[d]);
            step();
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_din", sd_buff_din, 0);
        chk("idle_ack", drv_sd_ack, 0);
        last_m = d;
        $display("txn drive=%0d rd=%0b wr=%0b lba=%08h keep=%0b", d, erd, ewr, lba_m[d], keep);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        for (int i = 0; i < D; i++) begin
            kind[i] = 0; lba_m[i] = '0; din_m[i] = '0;
        end
        #2;
        do_reset();

        // Drive 0 read, long ack.
        set_req(0, 0, 32'h0000_0123, 8'h3C);
        apply();
        run_txn(model_pick(pend, last_m), 1'b0, 0, 512);

        // Simultaneous reads on 0 and 1 after reset: 0 then 1.
        do_reset();
        set_req(0, 0, 32'h0000_1000, 8'h10);
        set_req(1, 0, 32'h0000_2000, 8'h20);
        apply();
        d = model_pick(pend, last_m);
        run_txn(d, 1'b0, 1, 3);
        d = model_pick(pend, last_m);
        run_txn(d, 1'b0, 0, 3);

        // Drive 1 write with distinctive buffer data.
        set_req(1, 1, 32'h0000_55AA, 8'hA5);
        apply();
        run_txn(model_pick(pend, last_m), 1'b0, 0, 4);

        // Drive 0 withdraws during REQ.
        set_req(0, 0, 32'h0000_0039, 8'h11);
        apply();
        step();
        chk("drop_grant_rd", sd_rd, 1);
        chk("drop_grant_active", active, 0);
        pend[0] = 1'b0;
        apply();
        step();
        chk("drop_rd", sd_rd, 0);
        chk("drop_busy", busy, 0);
        sd_ack = 1'b1;
        #1;
        chk("drop_no_ack", drv_sd_ack, 0);
        sd_ack = 1'b0;

        // Reset mid-transfer.
        set_req(2, 0, 32'hDEAD_0040, 8'h40);
        apply();
        step();
        chk("mid_grant_active", active, model_pick(pend, last_m));
        sd_ack = 1'b1;
        step();
        sd_buff_wr = 1'b1;
        #1;
        chk("mid_bwr", drv_sd_buff_wr, 3'b100);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd", sd_rd, 0);
        chk("mid_rst_wr", sd_wr, 0);
        chk("mid_rst_ack", drv_sd_ack, 0);
        chk("mid_rst_bwr", drv_sd_buff_wr, 0);
        chk("mid_rst_busy", busy, 0);
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        step();
        reset  = 1'b0;
        last_m = D - 1;
        run_txn(model_pick(pend, last_m), 1'b0, 0, 2);

        // Read and write together: read wins.
        set_req(0, 2, 32'h0000_0041, 8'h41);
        apply();
        run_txn(model_pick(pend, last_m), 1'b0, 0, 2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < D; i++)
                if (!pend[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, int'($urandom_range(0, 2)), $urandom, 8'($urandom_range(0, 255)));
            if (pend == '0)
                set_req(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 2)), $urandom,
                        8'($urandom_range(0, 255)));
            apply();
            d = model_pick(pend, last_m);
            run_txn(d, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iec_sd_arbiter.md
IEC_SD_ARBITER -- requirements
Module: iec_sd_arbiter

Interface
REQ-001 SHALL have parameter DRIVES, default 2, number of drive request ports (legal range 1..4).
REQ-002 SHALL have port clk_sys  in  1  system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port drv_sd_lba  in  32*DRIVES  per-drive block address; drive i uses bits [32*i+31:32*i].
REQ-005 SHALL have port drv_sd_rd  in  DRIVES  per-drive read request.
REQ-006 SHALL have port drv_sd_wr  in  DRIVES  per-drive write request.
REQ-007 SHALL have port drv_sd_ack  out  DRIVES  per-drive acknowledge.
REQ-008 SHALL have port drv_sd_buff_din  in  8*DRIVES  per-drive buffer data sent to the host on writes.
REQ-009 SHALL have port drv_sd_buff_wr  out  DRIVES  per-drive buffer write strobe.
REQ-010 SHALL have port sd_lba  out  32  host block address.
REQ-011 SHALL have port sd_rd  out  1  host read request.
REQ-012 SHALL have port sd_wr  out  1  host write request.
REQ-013 SHALL have port sd_ack  in  1  host acknowledge, high for the whole transfer.
REQ-014 SHALL have port sd_buff_wr  in  1  host buffer write strobe.
REQ-015 SHALL have port sd_buff_din  out  8  muxed drive buffer data to the host.
REQ-016 SHALL have port active  out  2  index of the granted drive.
REQ-017 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-018 sd_buff_addr and sd_buff_dout SHALL NOT pass through this block; they are broadcast to all drives externally.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, REQ, XFER.
REQ-020 In IDLE, SHALL scan drives round-robin, starting at (last+1) mod DRIVES, and grant the first drive i with drv_sd_rd[i] or drv_sd_wr[i] high.
REQ-021 On grant, SHALL latch idx<=i, sd_lba<=drv_sd_lba[i], sd_rd<=drv_sd_rd[i], sd_wr<=drv_sd_wr[i]&~drv_sd_rd[i] (read wins if both are high), and go to REQ; sd_rd/sd_wr SHALL be registered, one cycle after the request is sampled.
REQ-022 In REQ, when sd_ack=1, SHALL clear sd_rd and sd_wr and go to XFER.
REQ-023 In REQ, if the granted drive drops both its requests before sd_ack, SHALL clear sd_rd/sd_wr and return to IDLE with last unchanged; no ack is issued.
REQ-024 In XFER, when sd_ack=0, SHALL set last<=idx and go to IDLE.
REQ-025 drv_sd_ack[idx] SHALL equal sd_ack (combinational) in REQ and XFER; all other ack bits SHALL be 0.
REQ-026 drv_sd_buff_wr[idx] SHALL equal sd_buff_wr in XFER only; all other buff_wr bits SHALL be 0.
REQ-027 sd_buff_din SHALL be drv_sd_buff_din[idx] in REQ/XFER and 8'h00 in IDLE.
REQ-028 Requests on non-granted drives SHALL be ignored until IDLE and SHALL then be served in round-robin order; no drive is starved beyond DRIVES-1 transfers.
REQ-029 sd_lba SHALL stay stable from grant until the return to IDLE.
REQ-030 A request still high in the IDLE cycle right after XFER SHALL be treated as a new request.
REQ-031 active SHALL equal idx, zero-extended.

Reset
REQ-032 Asserting reset SHALL immediately force state=IDLE, sd_rd=0, sd_wr=0, sd_lba=0, idx=0, last=DRIVES-1, which makes all drv_sd_ack and drv_sd_buff_wr bits 0; this holds mid-transfer too.
REQ-033 After deassertion, drive 0 SHALL have first priority.

Structure
REQ-034 State encoding and the DRIVES limit constant SHALL live in the shared drive package.
REQ-035 The round-robin priority pick SHALL be one sub-module, rr_pick (request vector plus last index in, valid plus index out); everything else stays flat.

Verification
REQ-036 Drive 0 read: drv_sd_rd=01 with lba 0x00000123 -> sd_rd=1 next cycle, sd_lba=0x123; ack pulsed for 512 cycles -> drv_sd_ack=01, drv_sd_buff_wr reaches drive 0 only.
REQ-037 Simultaneous reads on drives 0 and 1 after reset -> drive 0 served first, then drive 1; active goes 0 then 1.
REQ-038 Drive 1 write with drv_sd_buff_din[15:8]=0xA5 -> sd_wr=1 and sd_buff_din=0xA5 during XFER; sd_buff_din=0x00 once back in IDLE.
REQ-039 Drive 0 drops its request in REQ before sd_ack -> sd_rd falls the next cycle, state returns to IDLE, no drv_sd_ack.
REQ-040 Reset asserted mid-XFER -> sd_rd/sd_wr=0, drv_sd_ack=00, busy=0 immediately; the next request is granted normally.
REQ-041 Drive 0 holds rd and wr high together -> sd_rd=1, sd_wr=0.
